// File: rtl/ibex_register_file_mp_pkg.sv
// ============================================================================
// Module : ibex_register_file_mp_pkg
// Brief  : Shared types and limits for the multi-ported register file slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ibex_register_file_mp_pkg;

    localparam int unsigned RfMaxReadPorts  = 4;
    localparam int unsigned RfMaxWritePorts = 2;

    typedef enum logic [1:0] {
        RfClrIdle  = 2'd0,
        RfClrClear = 2'd1,
        RfClrDone  = 2'd2
    } rf_clear_state_e;

endpackage

`default_nettype wire

// File: rtl/ibex_register_file_mp_if.sv
// ============================================================================
// Module : ibex_register_file_mp_if
// Brief  : Read/write/clear port bundle of the multi-ported register file.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ibex_register_file_mp_if #(
    parameter int unsigned NumReadPorts  = 2,
    parameter int unsigned NumWritePorts = 1,
    parameter int unsigned DataWidth     = 32
);
    logic [NumReadPorts-1:0][4:0]            raddr_i;
    logic [NumReadPorts-1:0][DataWidth-1:0]  rdata_o;
    logic [NumWritePorts-1:0][4:0]           waddr_i;
    logic [NumWritePorts-1:0][DataWidth-1:0] wdata_i;
    logic [NumWritePorts-1:0]                we_i;
    logic                                    clear_req_i;
    logic                                    clear_busy_o;
    logic                                    clear_done_o;

    modport master (
        output raddr_i, waddr_i, wdata_i, we_i, clear_req_i,
        input  rdata_o, clear_busy_o, clear_done_o
    );

    modport slave (
        input  raddr_i, waddr_i, wdata_i, we_i, clear_req_i,
        output rdata_o, clear_busy_o, clear_done_o
    );
endinterface

`default_nettype wire

// File: rtl/ibex_register_file_mp_clr_seq.sv
// ============================================================================
// Module : ibex_register_file_clr_seq
// Brief  : Clear sequencer walking x1..xN-1 once per request, then a done pulse.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ibex_register_file_clr_seq
    import ibex_register_file_mp_pkg::*;
#(
    parameter int unsigned NUM_WORDS  = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_i,
    input  wire logic                  i_clear_req,
    output logic                       o_clr_we,
    output logic [ADDR_WIDTH-1:0]      o_clr_addr,
    output logic                       o_busy,
    output logic                       o_done
);
    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NUM_WORDS - 1);

    rf_clear_state_e         r_state;
    rf_clear_state_e         w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic [ADDR_WIDTH-1:0]   w_ptr_nxt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= RfClrIdle;
            r_ptr   <= FIRST_ADDR;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        o_clr_we    = 1'b0;
        o_done      = 1'b0;
        o_busy      = (r_state != RfClrIdle);
        case (r_state)
            RfClrIdle: begin
                if (i_clear_req) begin
                    w_state_nxt = RfClrClear;
                    w_ptr_nxt   = FIRST_ADDR;
                end
            end
            RfClrClear: begin
                o_clr_we = 1'b1;
                // Pointer parks on the last word rather than wrapping into x0.
                if (r_ptr == LAST_ADDR) begin
                    w_state_nxt = RfClrDone;
                end else begin
                    w_ptr_nxt = r_ptr + FIRST_ADDR;
                end
            end
            RfClrDone: begin
                o_done      = 1'b1;
                w_state_nxt = RfClrIdle;
            end
            default: w_state_nxt = RfClrIdle;
        endcase
    end

    assign o_clr_addr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/ibex_register_file_mp.sv
// ============================================================================
// Module : ibex_register_file_mp
// Brief  : Flip-flop RISC-V register file with N read / M write ports and clear.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ibex_register_file_mp
    import ibex_register_file_mp_pkg::*;
#(
    parameter bit                   RV32E         = 1'b0,
    parameter int unsigned          DataWidth     = 32,
    parameter int unsigned          NumReadPorts  = 2,
    parameter int unsigned          NumWritePorts = 1,
    parameter bit                   WriteThrough  = 1'b0,
    parameter logic [DataWidth-1:0] WordZeroVal   = '0
) (
    input  wire logic               clk_i,
    input  wire logic               rst_i,
    ibex_register_file_mp_if.slave  bus
);
    localparam int unsigned NUM_WORDS  = RV32E ? 16 : 32;
    localparam int unsigned ADDR_WIDTH = RV32E ? 4 : 5;

    if ((NumReadPorts < 1) || (NumReadPorts > RfMaxReadPorts)) begin : g_bad_read_ports
        $error("NumReadPorts must be in 1..4");
    end
    if ((NumWritePorts < 1) || (NumWritePorts > RfMaxWritePorts)) begin : g_bad_write_ports
        $error("NumWritePorts must be in 1..2");
    end

    logic                   w_clr_we;
    logic [ADDR_WIDTH-1:0]  w_clr_addr;
    logic                   w_busy;
    logic                   w_done;
    logic [NumWritePorts-1:0] w_wvalid;
    logic [NUM_WORDS-1:0]   w_reg_we;
    logic [DataWidth-1:0]   w_reg_wdata [NUM_WORDS];
    logic [DataWidth-1:0]   r_mem       [NUM_WORDS];

    ibex_register_file_clr_seq #(
        .NUM_WORDS  (NUM_WORDS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clr_seq (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_clear_req (bus.clear_req_i),
        .o_clr_we    (w_clr_we),
        .o_clr_addr  (w_clr_addr),
        .o_busy      (w_busy),
        .o_done      (w_done)
    );

    assign bus.clear_busy_o = w_busy;
    assign bus.clear_done_o = w_done;

    // A write is accepted only when idle, non-x0, and inside the implemented range.
    for (genvar p = 0; p < NumWritePorts; p++) begin : g_wvalid
        assign w_wvalid[p] = bus.we_i[p] && !w_busy && (bus.waddr_i[p] != 5'd0) &&
                             (!RV32E || !bus.waddr_i[p][4]);
    end

    always_comb begin
        w_reg_we = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            w_reg_wdata[i] = WordZeroVal;
        end
        // Later ports overwrite earlier ones; the clear sequencer overrides all.
        for (int p = 0; p < NumWritePorts; p++) begin
            for (int i = 1; i < NUM_WORDS; i++) begin
                if (w_wvalid[p] && (bus.waddr_i[p][ADDR_WIDTH-1:0] == ADDR_WIDTH'(i))) begin
                    w_reg_we[i]    = 1'b1;
                    w_reg_wdata[i] = bus.wdata_i[p];
                end
            end
        end
        if (w_clr_we) begin
            w_reg_we[w_clr_addr]    = 1'b1;
            w_reg_wdata[w_clr_addr] = WordZeroVal;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                r_mem[i] <= WordZeroVal;
            end
        end else begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (w_reg_we[i]) begin
                    r_mem[i] <= w_reg_wdata[i];
                end
            end
        end
    end

    for (genvar r = 0; r < NumReadPorts; r++) begin : g_rd
        logic [DataWidth-1:0] w_rdata;
        always_comb begin
            w_rdata = r_mem[bus.raddr_i[r][ADDR_WIDTH-1:0]];
            if (WriteThrough) begin
                for (int p = 0; p < NumWritePorts; p++) begin
                    if (w_wvalid[p] && (bus.waddr_i[p] == bus.raddr_i[r])) begin
                        w_rdata = bus.wdata_i[p];
                    end
                end
            end
            if ((bus.raddr_i[r] == 5'd0) || (RV32E && bus.raddr_i[r][4])) begin
                w_rdata = WordZeroVal;
            end
        end
        assign bus.rdata_o[r] = w_rdata;
    end

endmodule

`default_nettype wire

// File: tb/tb_ibex_register_file_mp.sv
// ============================================================================
// Module : tb_ibex_register_file_mp
// Brief  : Scoreboard bench driving an RV32I/write-through and an RV32E/no-bypass file.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ibex_register_file_mp;
    localparam int NR = 3;
    localparam int NW = 2;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ibex_register_file_mp_if #(.NumReadPorts(NR), .NumWritePorts(NW), .DataWidth(DW)) if_a ();
    ibex_register_file_mp_if #(.NumReadPorts(NR), .NumWritePorts(NW), .DataWidth(DW)) if_b ();

    ibex_register_file_mp #(
        .RV32E(1'b0), .DataWidth(DW), .NumReadPorts(NR), .NumWritePorts(NW),
        .WriteThrough(1'b1), .WordZeroVal('0)
    ) u_dut_a (.clk_i(clk), .rst_i(rst), .bus(if_a));

    ibex_register_file_mp #(
        .RV32E(1'b1), .DataWidth(DW), .NumReadPorts(NR), .NumWritePorts(NW),
        .WriteThrough(1'b0), .WordZeroVal('0)
    ) u_dut_b (.clk_i(clk), .rst_i(rst), .bus(if_b));

    typedef struct packed {
        logic [1:0][NR-1:0][DW-1:0] rd;
        logic [1:0]                 busy;
        logic [1:0]                 done;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Stimulus for the current cycle, shared by both DUTs.
    logic [NW-1:0] s_we;
    logic [4:0]    s_wa [NW];
    logic [DW-1:0] s_wd [NW];
    logic [4:0]    s_ra [NR];
    logic          s_clr;
    logic          s_rst;

    // Reference model: d=0 is 32 regs with bypass, d=1 is 16 regs without.
    logic [DW-1:0] m_mem  [2][32];
    int            m_left [2];
    int            m_ptr  [2];

    function automatic logic [DW-1:0] model_read(int d, logic [4:0] a);
        logic [DW-1:0] v;
        if (a == 5'd0 || (d == 1 && a >= 5'd16)) return '0;
        v = m_mem[d][a];
        if (d == 0 && m_left[d] == 0) begin
            for (int q = 0; q < NW; q++) begin
                if (s_we[q] && s_wa[q] == a) v = s_wd[q];
            end
        end
        return v;
    endfunction

    task automatic model_step(int d);
        if (s_rst) begin
            for (int i = 0; i < 32; i++) m_mem[d][i] = '0;
            m_left[d] = 0;
        end else if (m_left[d] == 0) begin
            for (int q = 0; q < NW; q++) begin
                if (s_we[q] && s_wa[q] != 5'd0 && !(d == 1 && s_wa[q] >= 5'd16))
                    m_mem[d][s_wa[q]] = s_wd[q];
            end
            if (s_clr) begin
                m_left[d] = (d == 0) ? 32 : 16;
                m_ptr[d]  = 1;
            end
        end else if (m_left[d] > 1) begin
            m_mem[d][m_ptr[d]] = '0;
            m_ptr[d]++;
            m_left[d]--;
        end else begin
            m_left[d] = 0;
        end
    endtask

    task automatic idle();
        s_we = '0; s_clr = 1'b0; s_rst = 1'b0;
        for (int q = 0; q < NW; q++) begin s_wa[q] = '0; s_wd[q] = '0; end
        for (int r = 0; r < NR; r++) s_ra[r] = '0;
    endtask

    task automatic apply();
        rst = s_rst;
        if_a.we_i = s_we; if_b.we_i = s_we;
        if_a.clear_req_i = s_clr; if_b.clear_req_i = s_clr;
        for (int q = 0; q < NW; q++) begin
            if_a.waddr_i[q] = s_wa[q]; if_b.waddr_i[q] = s_wa[q];
            if_a.wdata_i[q] = s_wd[q]; if_b.wdata_i[q] = s_wd[q];
        end
        for (int r = 0; r < NR; r++) begin
            if_a.raddr_i[r] = s_ra[r]; if_b.raddr_i[r] = s_ra[r];
        end
    endtask

    task automatic tick();
        exp_t e;
        apply();
        for (int d = 0; d < 2; d++) begin
            e.busy[d] = (m_left[d] != 0);
            e.done[d] = (m_left[d] == 1);
            for (int r = 0; r < NR; r++) e.rd[d][r] = model_read(d, s_ra[r]);
        end
        exp_q.push_back(e);
        for (int d = 0; d < 2; d++) model_step(d);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    // Monitor: compares the DUT outputs of each cycle against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int r = 0; r < NR; r++) begin
                chk($sformatf("a.rdata[%0d]", r), if_a.rdata_o[r], e.rd[0][r]);
                chk($sformatf("b.rdata[%0d]", r), if_b.rdata_o[r], e.rd[1][r]);
            end
            chk("a.busy", {31'd0, if_a.clear_busy_o}, {31'd0, e.busy[0]});
            chk("b.busy", {31'd0, if_b.clear_busy_o}, {31'd0, e.busy[1]});
            chk("a.done", {31'd0, if_a.clear_done_o}, {31'd0, e.done[0]});
            chk("b.done", {31'd0, if_b.clear_done_o}, {31'd0, e.done[1]});
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32; i++) m_mem[d][i] = '0;
            m_left[d] = 0;
            m_ptr[d]  = 1;
        end
        idle();
        s_rst = 1'b1;
        apply();
        @(posedge clk);
        #1;
        tick();
        idle(); tick();

        // Reset wipes a written register
        idle(); s_we = 2'b01; s_wa[0] = 5'd5; s_wd[0] = 32'hDEAD_BEEF; s_ra[0] = 5'd5; tick();
        idle(); s_ra[0] = 5'd5; tick();
        idle(); s_rst = 1'b1; s_ra[0] = 5'd5; tick();
        idle(); s_ra[0] = 5'd5; tick();

        // Same address on both write ports: port 1 wins
        idle(); s_we = 2'b11; s_wa[0] = 5'd7; s_wa[1] = 5'd7;
        s_wd[0] = 32'h1111; s_wd[1] = 32'h2222; s_ra[0] = 5'd7; tick();
        idle(); s_ra[0] = 5'd7; s_ra[1] = 5'd7; tick();

        // x0 is never stored
        idle(); s_we = 2'b01; s_wa[0] = 5'd0; s_wd[0] = 32'hFFFF_FFFF; tick();
        idle(); tick();

        // Bypass versus registered read of x3
        idle(); s_we = 2'b01; s_wa[0] = 5'd3; s_wd[0] = 32'hA5A5; s_ra[0] = 5'd3; tick();
        idle(); s_ra[0] = 5'd3; tick();

        // Fill x1..x31 with their index, then clear with a dropped mid-clear write
        for (int i = 1; i < 32; i++) begin
            idle(); s_we = 2'b01; s_wa[0] = 5'(i); s_wd[0] = 32'(i); s_ra[0] = 5'(i); tick();
        end
        idle(); s_clr = 1'b1; tick();
        for (int k = 0; k < 34; k++) begin
            idle();
            if (k == 8) begin s_we = 2'b01; s_wa[0] = 5'd9; s_wd[0] = 32'h999; end
            for (int r = 0; r < NR; r++) s_ra[r] = 5'($urandom_range(0, 31));
            tick();
        end
        for (int a = 0; a < 32; a += NR) begin
            idle();
            for (int r = 0; r < NR; r++) s_ra[r] = 5'(a + r);
            tick();
        end

        // Reset in the middle of a clear
        for (int i = 1; i < 32; i++) begin
            idle(); s_we = 2'b10; s_wa[1] = 5'(i); s_wd[1] = 32'h100 + 32'(i); tick();
        end
        idle(); s_clr = 1'b1; tick();
        for (int k = 0; k < 10; k++) begin
            idle(); s_ra[0] = 5'(k + 1); s_ra[1] = 5'(k + 15); tick();
        end
        idle(); s_rst = 1'b1; tick();
        for (int k = 0; k < 40; k++) begin
            idle(); s_ra[0] = 5'($urandom_range(0, 31)); tick();
        end

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            idle();
            s_we = 2'($urandom_range(0, 3));
            for (int q = 0; q < NW; q++) begin
                s_wa[q] = 5'($urandom_range(0, 31));
                s_wd[q] = $urandom();
            end
            if ($urandom_range(0, 3) == 0) s_wa[1] = s_wa[0];
            for (int r = 0; r < NR; r++) begin
                s_ra[r] = ($urandom_range(0, 2) == 0) ? s_wa[r % NW] : 5'($urandom_range(0, 31));
            end
            s_clr = ($urandom_range(0, 119) == 0);
            s_rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        idle(); tick();

        repeat (3) @(posedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
